// File: rtl/riscv_muldiv_unit.sv
// -----------------------------------------------------------------------------
// riscv_muldiv_unit
//   Iterative RV32M/RV64M multiply/divide unit for the EX stage. One operation
//   at a time: shift-add multiply or restoring division over XLEN cycles on
//   operand magnitudes, then one FIX cycle applying signs and selecting the
//   high/low half before the result is presented with its destination tag.
//   Divide-by-zero and signed overflow bypass CALC/FIX and finish in 1 cycle.
//
// Build option:
//   MULDIV_EARLY_OUT_EN - multiply leaves CALC once the remaining multiplier
//                         magnitude is zero (a zero multiplier skips CALC).
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   request handshake; in_ready is high only in IDLE
//   in_funct3             000 MUL 001 MULH 010 MULHSU 011 MULHU
//                         100 DIV 101 DIVU 110 REM    111 REMU
//   in_op_a, in_op_b      rs1 / rs2 operands (XLEN)
//   in_tag                destination register tag (TAG_W)
//   out_valid / out_ready result handshake; result and tag held while stalled
//   out_result, out_tag   result (XLEN) and its tag (TAG_W)
//   flush                 synchronous kill of any pending/in-flight operation
// -----------------------------------------------------------------------------
module riscv_muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_op_a,
  input  logic [XLEN-1:0]  in_op_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  input  logic             flush
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]        r_f3;
  logic [TAG_W-1:0]  r_tag;
  logic              r_neg_q;   // product / quotient sign
  logic              r_neg_r;   // remainder sign (dividend's sign)
  logic [2*XLEN-1:0] r_acc;     // mul: product; div: {remainder, dividend/quotient}
  logic [2*XLEN-1:0] r_mcand;   // mul: shifted multiplicand; div: divisor in low half
  logic [XLEN-1:0]   r_mplier;  // mul: remaining multiplier bits
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_result;

  // ---------------------------------------------------------------------------
  // Input decode (used only on the accept edge)
  // ---------------------------------------------------------------------------
  logic            w_accept;
  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic            w_skip_calc;

  assign w_accept   = in_valid && (r_state == S_IDLE) && !flush;
  assign w_is_div   = in_funct3[2];
  // Divide: funct3[0]==0 is signed. Multiply: MULH/MULHSU sign rs1, MULH signs rs2.
  assign w_a_signed = w_is_div ? !in_funct3[0]
                               : (in_funct3[1:0] == 2'b01) || (in_funct3[1:0] == 2'b10);
  assign w_b_signed = w_is_div ? !in_funct3[0] : (in_funct3[1:0] == 2'b01);
  assign w_a_neg    = w_a_signed && in_op_a[XLEN-1];
  assign w_b_neg    = w_b_signed && in_op_b[XLEN-1];
  assign w_mag_a    = w_a_neg ? ('0 - in_op_a) : in_op_a;
  assign w_mag_b    = w_b_neg ? ('0 - in_op_b) : in_op_b;

  assign w_div_zero = (in_op_b == '0);
  assign w_div_ovf  = !in_funct3[0] && (in_op_a == MIN_NEG) && (in_op_b == '1);
  assign w_special  = w_is_div && (w_div_zero || w_div_ovf);
  // funct3[1] selects REM/REMU over DIV/DIVU.
  assign w_special_res = w_div_zero ? (in_funct3[1] ? in_op_a : '1)
                                    : (in_funct3[1] ? '0 : in_op_a);

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] w_mul_acc;
  logic [XLEN:0]     w_trial;
  logic              w_q_bit;
  logic [XLEN-1:0]   w_rem_nxt;
  logic [2*XLEN-1:0] w_div_acc;
  logic              w_last_iter;
  logic              w_early_exit;

  assign w_mul_acc = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // Restoring step: partial remainder with the next dividend bit shifted in,
  // minus the divisor; a non-negative trial keeps the difference.
  assign w_trial   = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_mcand[XLEN-1:0]};
  assign w_q_bit   = !w_trial[XLEN];
  assign w_rem_nxt = w_q_bit ? w_trial[XLEN-1:0] : r_acc[2*XLEN-2:XLEN-1];
  assign w_div_acc = {w_rem_nxt, r_acc[XLEN-2:0], w_q_bit};

  assign w_last_iter = (r_cnt == LAST_CNT);

`ifdef MULDIV_EARLY_OUT_EN
  assign w_skip_calc  = !w_is_div && (w_mag_b == '0);
  assign w_early_exit = !r_f3[2] && (r_mplier[XLEN-1:1] == '0);
`else
  assign w_skip_calc  = 1'b0;
  assign w_early_exit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Sign fix-up and result select
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_remd;
  logic [XLEN-1:0]   w_fix_res;

  assign w_prod = r_neg_q ? ('0 - r_acc) : r_acc;
  assign w_quot = r_neg_q ? ('0 - r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
  assign w_remd = r_neg_r ? ('0 - r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = '0;
    if (r_f3[2]) begin
      w_fix_res = r_f3[1] ? w_remd : w_quot;
    end else if (r_f3[1:0] == 2'b00) begin
      w_fix_res = w_prod[XLEN-1:0];
    end else begin
      w_fix_res = w_prod[2*XLEN-1:XLEN];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_special) begin
            w_state_nxt = S_DONE;
          end else if (w_skip_calc) begin
            w_state_nxt = S_FIX;
          end else begin
            w_state_nxt = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (w_last_iter || w_early_exit) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (flush) begin
      w_state_nxt = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f3     <= '0;
      r_tag    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_f3    <= in_funct3;
            r_tag   <= in_tag;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_cnt   <= '0;
            if (w_is_div) begin
              r_acc    <= {{XLEN{1'b0}}, w_mag_a};
              r_mcand  <= {{XLEN{1'b0}}, w_mag_b};
              r_mplier <= '0;
            end else begin
              r_acc    <= '0;
              r_mcand  <= {{XLEN{1'b0}}, w_mag_a};
              r_mplier <= w_mag_b;
            end
            if (w_special) begin
              r_result <= w_special_res;
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_f3[2]) begin
            r_acc <= w_div_acc;
          end else begin
            r_acc    <= w_mul_acc;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end
        end
        S_FIX: begin
          r_result <= w_fix_res;
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign out_result = r_result;
  assign out_tag    = r_tag;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
`timescale 1ns/1ps
module tb_riscv_muldiv_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_HSU = 4;   // |rs2| = 2, highest set bit 1
  localparam int LAT_SML = 5;   // |rs2| = 7, highest set bit 2
`else
  localparam int LAT_HSU = 34;
  localparam int LAT_SML = 34;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_funct3;
  logic [XLEN-1:0]  in_op_a;
  logic [XLEN-1:0]  in_op_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             flush;

  riscv_muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_funct3  (in_funct3),
    .in_op_a    (in_op_a),
    .in_op_b    (in_op_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .flush      (flush)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
    int               lat;   // 0: latency not checked
  } exp_t;

  exp_t  sb[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    acc_cyc = 0;
  bit    seen = 1'b0;
  string cur_name = "reset";

  task automatic chk(input string what, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", cur_name, what, act, exp);
    end
  endtask

  // Scoreboard monitor: notes accept cycle, compares each presented result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (in_valid && in_ready && !flush) begin
        acc_cyc = cyc;
        seen    = 1'b0;
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL %s/spurious: got out_valid tag %0d result 0x%0h, expected none",
                   cur_name, out_tag, out_result);
        end else begin
          e = sb[0];
          if (!seen) begin
            seen = 1'b1;
            if (e.lat != 0) chk("latency", 64'(cyc - acc_cyc), 64'(e.lat));
          end
          chk("result", out_result, e.res);
          chk("tag", out_tag, e.tag);
          if (!out_ready) chk("in_ready_stall", in_ready, 0);
          else void'(sb.pop_front());
        end
      end
    end
  end

  task automatic issue(input string nm, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag,
                       input logic [31:0] exp, input int lat, input bit push);
    exp_t e;
    @(posedge clk); #1;
    cur_name = nm;
    chk("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    in_funct3 = f3;
    in_op_a   = a;
    in_op_b   = b;
    in_tag    = tag;
    if (push) begin
      e.res = exp;
      e.tag = tag;
      e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    // Operands are captured on the accept edge; scramble them afterwards.
    in_valid  = 1'b0;
    in_funct3 = 3'($urandom);
    in_op_a   = $urandom;
    in_op_b   = $urandom;
    in_tag    = 5'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s/timeout: got no result after %0d cycles, expected one", cur_name, n);
      sb.delete();
    end
  endtask

  task automatic op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] b, input logic [4:0] tag,
                    input logic [31:0] exp, input int lat);
    issue(nm, f3, a, b, tag, exp, lat, 1'b1);
    wait_done();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_funct3 = '0;
    in_op_a   = '0;
    in_op_b   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("in_ready", in_ready, 1);
    chk("out_valid", out_valid, 0);
    chk("out_result", out_result, 0);
    chk("out_tag", out_tag, 0);
    rst_n = 1'b1;

    op("MUL",    3'b000, 32'd7,        32'hFFFF_FFFD, 5'd10, 32'hFFFF_FFEB, 34);
    op("MULH",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd3,  32'h4000_0000, 34);
    op("MULHU",  3'b011, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, 34);
    op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'd2,         5'd7,  32'hFFFF_FFFF, LAT_HSU);
    op("MULHU1", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFE, 34);
    op("DIV",    3'b100, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFD, 34);
    op("REM",    3'b110, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFF, 34);
    op("DIVU",   3'b101, 32'd100,       32'd7,         5'd12, 32'd14,        34);
    op("REMU",   3'b111, 32'd100,       32'd7,         5'd13, 32'd2,         34);
    op("DIVU0",  3'b101, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, 1);
    op("REMU0",  3'b111, 32'd5,         32'd0,         5'd15, 32'd5,         1);
    op("DIVOVF", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1);
    op("REMOVF", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         1);
    op("DIV0",   3'b100, 32'hFFFF_FFF9, 32'd0,         5'd18, 32'hFFFF_FFFF, 1);
    op("REM0",   3'b110, 32'hFFFF_FFF9, 32'd0,         5'd19, 32'hFFFF_FFF9, 1);

    // Consumer stall of 10 cycles, then a back-to-back accept.
    out_ready = 1'b0;
    issue("STALL", 3'b111, 32'd100, 32'd7, 5'd21, 32'd2, 34, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL STALL/timeout: got out_valid=0, expected 1");
    end
    repeat (10) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done();
    op("B2B", 3'b101, 32'd100, 32'd7, 5'd22, 32'd14, 34);

    // Flush during CALC cycle 12.
    issue("FLUSH", 3'b101, 32'd100, 32'd7, 5'd23, 32'd0, 0, 1'b0);
    repeat (11) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("in_ready_after_flush", in_ready, 1);
    chk("out_valid_after_flush", out_valid, 0);
    repeat (40) @(posedge clk);

    // Flush and request together: nothing accepted.
    cur_name = "FLUSH_REQ";
    #1;
    in_valid  = 1'b1;
    in_funct3 = 3'b101;
    in_op_a   = 32'd100;
    in_op_b   = 32'd7;
    flush     = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("in_ready_not_accepted", in_ready, 1);
    repeat (3) @(posedge clk);

    // Asynchronous reset mid-CALC.
    issue("RESET", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd24, 32'd0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("in_ready_async", in_ready, 1);
    chk("out_valid_async", out_valid, 0);
    chk("out_result_async", out_result, 0);
    chk("out_tag_async", out_tag, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    op("MUL_POSTRST", 3'b000, 32'd6, 32'd7, 5'd1, 32'd42, LAT_SML);

    wait_done();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_muldiv_unit.md
Name: riscv_muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply/divide unit, attached beside the single-cycle ALU in the EX stage of the pipelined core.
- Accepts one operation at a time through a valid/ready handshake.
- Computes the result over XLEN cycles using shift-add multiply or restoring division, then returns the result with its destination tag.
- The pipeline holds EX while in_ready or out_valid is low, and can kill an in-flight operation with flush on a branch or jump redirect.

Parameters:
- XLEN, 32: operand and result width; legal values are 32 and 64.
- TAG_W, 5: width of the destination-register tag carried with each operation.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept an operation (state IDLE).
- in_funct3  in  3  opcode: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_op_a  in  XLEN  rs1 value, already forwarded.
- in_op_b  in  XLEN  rs2 value, already forwarded.
- in_tag  in  TAG_W  destination register index.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_result  out  XLEN  result.
- out_tag  out  TAG_W  tag of the operation being returned.
- flush  in  1  synchronous kill of any in-flight or pending operation.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, out_result=0, out_tag=0.
  - All internal accumulators and counters clear.
  - Reset asserted mid-operation discards the operation with no result produced.
- States and transitions:
  - IDLE -> CALC when in_valid && in_ready && !flush (the accept edge).
  - CALC -> FIX after XLEN iterations.
  - FIX -> DONE after one cycle (sign correction and high/low select).
  - DONE -> IDLE when out_ready is high.
  - Any state -> IDLE on flush: out_valid drops the next cycle, and any result is discarded.
  - flush and in_valid in the same cycle: flush wins and nothing is accepted.
- Latency: out_valid asserts XLEN+2 cycles after the accept edge (34 for XLEN=32). The unit is not pipelined; in_ready=0 from the accept edge until DONE is exited.
- Operand capture: operands, funct3 and tag are registered on the accept edge, so later input changes are ignored.
- Multiply:
  - Operands are converted to magnitudes according to signedness: MULH signed×signed, MULHSU signed×unsigned, MULHU and MUL unsigned handling with a 2·XLEN product.
  - FIX negates the 2·XLEN product when the result sign is negative.
  - MUL returns the low XLEN bits; the MULH* variants return the high XLEN bits.
- Divide:
  - Restoring division on magnitudes; one quotient bit per cycle, MSB first.
  - FIX applies signs: the quotient is negative when the operand signs differ; the remainder takes the dividend's sign.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases (IDLE -> DONE directly, so out_valid asserts 1 cycle after accept):
  - Divisor = 0: DIV/DIVU return all-ones; REM/REMU return the dividend.
  - Signed overflow (dividend = -2^(XLEN-1), divisor = -1): DIV returns the dividend; REM returns 0.
- Output hold: out_result and out_tag stay stable while out_valid=1 && out_ready=0. A consumer stall of any length is legal.
- Back-to-back: a new accept is possible in the cycle after DONE exits, because in_ready returns to 1 in IDLE.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined (multiply only): CALC exits to FIX as soon as the remaining shifted multiplier magnitude is zero, so latency = (index of highest set bit of |multiplier|) + 3 cycles. A multiplier of 0 takes 2 cycles from accept to out_valid. Divide latency is unchanged.
- Undefined: fixed XLEN+2 latency for all non-special operations.

Test Plan (XLEN=32):
- MUL a=7, b=0xFFFFFFFD (-3), out_ready=1 -> out_result=0xFFFFFFEB, out_valid exactly 34 cycles after accept, out_tag echoes in_tag=5'd10.
- MULH a=b=0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with out_valid 1 cycle after accept; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM with the same operands -> 0, also 1 cycle.
- Hold out_ready=0 for 10 cycles after out_valid -> out_result and out_tag stable, in_ready=0; release -> IDLE, and a new op is accepted the next cycle.
- flush at CALC cycle 12 -> IDLE next cycle, no out_valid. Deassert rst_n asynchronously mid-CALC -> in_ready=1 and out_valid=0 immediately.
